// File: rtl/id_exe_forward_stage.sv
// ID->EXE pipeline register with load-use / RAW hazard detection, bubble insertion,
// EXE operand forwarding muxes and a saturating stall-cycle counter.
module id_exe_forward_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CMD_W  = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fwd_en,
   input  logic              flush,
   input  logic [REG_W-1:0]  id_src1,
   input  logic [REG_W-1:0]  id_src2,
   input  logic              id_two_src,
   input  logic [REG_W-1:0]  id_dest,
   input  logic [DATA_W-1:0] id_val1,
   input  logic [DATA_W-1:0] id_val2,
   input  logic [DATA_W-1:0] id_st_val,
   input  logic [CMD_W-1:0]  id_cmd,
   input  logic              id_mem_r_en,
   input  logic              id_mem_w_en,
   input  logic              id_wb_en,
   input  logic              mem_wb_en,
   input  logic [REG_W-1:0]  mem_dest,
   input  logic [1:0]        sel_a,
   input  logic [1:0]        sel_b,
   input  logic [1:0]        sel_st,
   input  logic [DATA_W-1:0] mem_alu_res,
   input  logic [DATA_W-1:0] wb_value,
   output logic              hazard_stall,
   output logic [REG_W-1:0]  exe_src1,
   output logic [REG_W-1:0]  exe_src2,
   output logic [REG_W-1:0]  exe_dest,
   output logic [CMD_W-1:0]  exe_cmd,
   output logic              exe_mem_r_en,
   output logic              exe_mem_w_en,
   output logic              exe_wb_en,
   output logic [DATA_W-1:0] exe_alu_a,
   output logic [DATA_W-1:0] exe_alu_b,
   output logic [DATA_W-1:0] exe_st_val,
   output logic [CNT_W-1:0]  stall_count
);

   logic [REG_W-1:0]  src1_q, src1_d, src2_q, src2_d, dest_q, dest_d;
   logic [CMD_W-1:0]  cmd_q, cmd_d;
   logic              mem_r_en_q, mem_r_en_d, mem_w_en_q, mem_w_en_d;
   logic              wb_en_q, wb_en_d, two_src_q, two_src_d;
   logic [DATA_W-1:0] val1_q, val1_d, val2_q, val2_d, st_val_q, st_val_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              raw_exe, raw_mem, stall;

   // A source matches a destination only for nonzero indices; src2 only when read.
   function automatic logic id_reads(input logic [REG_W-1:0] d,
                                     input logic [REG_W-1:0] s1,
                                     input logic [REG_W-1:0] s2,
                                     input logic             two);
      return ((s1 != '0) && (s1 == d)) || (two && (s2 != '0) && (s2 == d));
   endfunction

   function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0]        sel,
                                                 input logic              en,
                                                 input logic [DATA_W-1:0] reg_val,
                                                 input logic [DATA_W-1:0] mem_val,
                                                 input logic [DATA_W-1:0] wb_val);
      logic [DATA_W-1:0] res;
      res = reg_val;
      if (en) begin
         unique case (sel)
            2'b01:   res = mem_val;
            2'b10:   res = wb_val;
            default: res = reg_val;
         endcase
      end
      return res;
   endfunction

   always_comb begin
      raw_exe = wb_en_q & id_reads(dest_q, id_src1, id_src2, id_two_src);
      raw_mem = mem_wb_en & id_reads(mem_dest, id_src1, id_src2, id_two_src);
      stall   = fwd_en ? (mem_r_en_q & raw_exe) : (raw_exe | raw_mem);
      hazard_stall = stall & ~flush;
   end

   always_comb begin
      src1_d     = '0;
      src2_d     = '0;
      dest_d     = '0;
      cmd_d      = '0;
      mem_r_en_d = 1'b0;
      mem_w_en_d = 1'b0;
      wb_en_d    = 1'b0;
      two_src_d  = 1'b0;
      val1_d     = '0;
      val2_d     = '0;
      st_val_d   = '0;
      if (!(flush || hazard_stall)) begin
         src1_d     = id_src1;
         src2_d     = id_two_src ? id_src2 : '0;
         dest_d     = id_dest;
         cmd_d      = id_cmd;
         mem_r_en_d = id_mem_r_en;
         mem_w_en_d = id_mem_w_en;
         wb_en_d    = id_wb_en;
         two_src_d  = id_two_src;
         val1_d     = id_val1;
         val2_d     = id_val2;
         st_val_d   = id_st_val;
      end
      cnt_d = cnt_q;
      if (hazard_stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src1_q     <= '0;
         src2_q     <= '0;
         dest_q     <= '0;
         cmd_q      <= '0;
         mem_r_en_q <= 1'b0;
         mem_w_en_q <= 1'b0;
         wb_en_q    <= 1'b0;
         two_src_q  <= 1'b0;
         val1_q     <= '0;
         val2_q     <= '0;
         st_val_q   <= '0;
         cnt_q      <= '0;
      end else begin
         src1_q     <= src1_d;
         src2_q     <= src2_d;
         dest_q     <= dest_d;
         cmd_q      <= cmd_d;
         mem_r_en_q <= mem_r_en_d;
         mem_w_en_q <= mem_w_en_d;
         wb_en_q    <= wb_en_d;
         two_src_q  <= two_src_d;
         val1_q     <= val1_d;
         val2_q     <= val2_d;
         st_val_q   <= st_val_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      exe_src1     = src1_q;
      exe_src2     = src2_q;
      exe_dest     = dest_q;
      exe_cmd      = cmd_q;
      exe_mem_r_en = mem_r_en_q;
      exe_mem_w_en = mem_w_en_q;
      exe_wb_en    = wb_en_q;
      stall_count  = cnt_q;
      exe_alu_a    = fwd_mux(sel_a, fwd_en, val1_q, mem_alu_res, wb_value);
      // Operand B is an immediate unless the instruction actually reads src2.
      exe_alu_b    = two_src_q ? fwd_mux(sel_b, fwd_en, val2_q, mem_alu_res, wb_value)
                               : val2_q;
      exe_st_val   = fwd_mux(sel_st, fwd_en, st_val_q, mem_alu_res, wb_value);
   end

endmodule

// File: tb/tb_id_exe_forward_stage.sv
// Directed + random bench for id_exe_forward_stage against a behavioural EXE-slot model.
module tb_id_exe_forward_stage;

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;
   localparam int unsigned CW = 4;
   localparam int unsigned NW = 4;

   logic          clk = 1'b0;
   logic          rst, fwd_en, flush;
   logic [RW-1:0] id_src1, id_src2, id_dest, mem_dest;
   logic          id_two_src, id_mem_r_en, id_mem_w_en, id_wb_en, mem_wb_en;
   logic [DW-1:0] id_val1, id_val2, id_st_val, mem_alu_res, wb_value;
   logic [CW-1:0] id_cmd;
   logic [1:0]    sel_a, sel_b, sel_st;
   logic          hazard_stall, exe_mem_r_en, exe_mem_w_en, exe_wb_en;
   logic [RW-1:0] exe_src1, exe_src2, exe_dest;
   logic [CW-1:0] exe_cmd;
   logic [DW-1:0] exe_alu_a, exe_alu_b, exe_st_val;
   logic [NW-1:0] stall_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_exe_forward_stage #(.DATA_W(DW), .REG_W(RW), .CMD_W(CW), .CNT_W(NW)) dut (
      .clk(clk), .rst(rst), .fwd_en(fwd_en), .flush(flush),
      .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest),
      .id_val1(id_val1), .id_val2(id_val2), .id_st_val(id_st_val), .id_cmd(id_cmd),
      .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_wb_en(id_wb_en),
      .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
      .sel_a(sel_a), .sel_b(sel_b), .sel_st(sel_st),
      .mem_alu_res(mem_alu_res), .wb_value(wb_value),
      .hazard_stall(hazard_stall), .exe_src1(exe_src1), .exe_src2(exe_src2),
      .exe_dest(exe_dest), .exe_cmd(exe_cmd), .exe_mem_r_en(exe_mem_r_en),
      .exe_mem_w_en(exe_mem_w_en), .exe_wb_en(exe_wb_en),
      .exe_alu_a(exe_alu_a), .exe_alu_b(exe_alu_b), .exe_st_val(exe_st_val),
      .stall_count(stall_count)
   );

   // Model of the instruction sitting in EXE.
   typedef struct packed {
      logic [RW-1:0] src1, src2, dest;
      logic [CW-1:0] cmd;
      logic          rd, wr, wb, two;
      logic [DW-1:0] v1, v2, st;
   } slot_t;

   slot_t       m;
   int unsigned m_cnt;
   int unsigned cnt_max = (1 << NW) - 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit reads(input logic [RW-1:0] d);
      return (id_src1 != 0 && id_src1 == d) || (id_two_src && id_src2 != 0 && id_src2 == d);
   endfunction

   function automatic bit model_stall();
      bit s;
      if (fwd_en) s = m.rd && m.wb && reads(m.dest);
      else        s = (m.wb && reads(m.dest)) || (mem_wb_en && reads(mem_dest));
      return s && !flush;
   endfunction

   function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] r);
      if (fwd_en && sel == 2'd1) return mem_alu_res;
      if (fwd_en && sel == 2'd2) return wb_value;
      return r;
   endfunction

   task automatic tick();
      slot_t nx;
      bit    st;
      #2;
      st = model_stall();
      chk("hazard_stall", hazard_stall, st);
      chk("exe_src1", exe_src1, m.src1);
      chk("exe_src2", exe_src2, m.src2);
      chk("exe_dest", exe_dest, m.dest);
      chk("exe_cmd", exe_cmd, m.cmd);
      chk("exe_mem_r_en", exe_mem_r_en, m.rd);
      chk("exe_mem_w_en", exe_mem_w_en, m.wr);
      chk("exe_wb_en", exe_wb_en, m.wb);
      chk("exe_alu_a", exe_alu_a, pick(sel_a, m.v1));
      chk("exe_alu_b", exe_alu_b, m.two ? pick(sel_b, m.v2) : m.v2);
      chk("exe_st_val", exe_st_val, pick(sel_st, m.st));
      chk("stall_count", stall_count, m_cnt);
      nx = '0;
      if (!rst && !flush && !st)
         nx = '{src1: id_src1, src2: (id_two_src ? id_src2 : '0), dest: id_dest,
                cmd: id_cmd, rd: id_mem_r_en, wr: id_mem_w_en, wb: id_wb_en,
                two: id_two_src, v1: id_val1, v2: id_val2, st: id_st_val};
      @(posedge clk);
      #1;
      m = nx;
      if (rst) m_cnt = 0;
      else if (st && m_cnt < cnt_max) m_cnt++;
   endtask

   task automatic idle();
      {fwd_en, flush, id_two_src, id_mem_r_en, id_mem_w_en, id_wb_en, mem_wb_en} = '0;
      {id_src1, id_src2, id_dest, mem_dest, id_cmd, sel_a, sel_b, sel_st} = '0;
      {id_val1, id_val2, id_st_val, mem_alu_res, wb_value} = '0;
   endtask

   task automatic set_id(input logic [RW-1:0] s1, input logic [RW-1:0] s2, input logic two,
                         input logic [RW-1:0] d, input logic rd, input logic wb,
                         input logic [DW-1:0] v1);
      id_src1 = s1; id_src2 = s2; id_two_src = two; id_dest = d;
      id_mem_r_en = rd; id_mem_w_en = 1'b0; id_wb_en = wb; id_val1 = v1;
      id_val2 = v1 ^ 32'h0F0F_0F0F; id_st_val = v1 + 32'd7; id_cmd = CW'(d);
   endtask

   initial begin
      int unsigned saved;
      rst = 1'b1;
      idle();
      @(posedge clk);
      @(posedge clk);
      #1;
      m = '0;
      m_cnt = 0;
      rst = 1'b0;
      #1;
      chk("reset_stall", hazard_stall, 0);
      chk("reset_count", stall_count, 0);
      chk("reset_wb", exe_wb_en, 0);
      tick();

      // Load-use: LD r3 in EXE, ADD r4,r3,r5 in ID.
      fwd_en = 1'b1;
      set_id(5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 32'h100);
      tick();
      set_id(5'd3, 5'd5, 1'b1, 5'd4, 1'b0, 1'b1, 32'h200);
      #1 chk("lu_stall", hazard_stall, 1);
      tick();
      chk("lu_bubble_wb", exe_wb_en, 0);
      chk("lu_count", stall_count, 1);
      tick();
      chk("lu_add_dest", exe_dest, 4);
      chk("lu_add_src2", exe_src2, 5);

      // Forwarding selects on a registered ADD with src1=r2.
      idle();
      fwd_en = 1'b1;
      set_id(5'd2, 5'd6, 1'b1, 5'd9, 1'b0, 1'b1, 32'h1234);
      tick();
      idle();
      fwd_en = 1'b1;
      sel_a = 2'd1; mem_alu_res = 32'hAA;
      #1 chk("fwd_mem", exe_alu_a, 32'hAA);
      sel_a = 2'd2; wb_value = 32'h55;
      #1 chk("fwd_wb", exe_alu_a, 32'h55);
      sel_a = 2'd3;
      #1 chk("fwd_rsv", exe_alu_a, 32'h1234);
      fwd_en = 1'b0; sel_a = 2'd1;
      #1 chk("fwd_off", exe_alu_a, 32'h1234);
      tick();

      // No forwarding: MEM-stage dependency stalls, r0 never does.
      idle();
      mem_wb_en = 1'b1; mem_dest = 5'd7;
      set_id(5'd7, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, 32'h77);
      #1 chk("nofwd_stall", hazard_stall, 1);
      mem_dest = 5'd0; id_src1 = 5'd0;
      #1 chk("nofwd_r0", hazard_stall, 0);
      tick();

      // Load-use with flush the same cycle.
      idle();
      fwd_en = 1'b1;
      set_id(5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 32'h300);
      tick();
      saved = m_cnt;
      set_id(5'd3, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1, 32'h400);
      flush = 1'b1;
      #1 chk("flush_stall", hazard_stall, 0);
      tick();
      chk("flush_bubble", exe_wb_en, 0);
      chk("flush_count", stall_count, saved);

      // Saturation, then reset in the middle of a stall.
      idle();
      mem_wb_en = 1'b1; mem_dest = 5'd7;
      set_id(5'd7, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, 32'h88);
      for (int i = 0; i < (1 << NW) + 3; i++) tick();
      chk("sat_count", stall_count, cnt_max);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_count", stall_count, 0);

      // Random traffic with small register indices to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         fwd_en = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 7) == 0);
         id_src1 = RW'($urandom_range(0, 3));
         id_src2 = RW'($urandom_range(0, 3));
         id_dest = RW'($urandom_range(0, 3));
         mem_dest = RW'($urandom_range(0, 3));
         {id_two_src, id_mem_r_en, id_mem_w_en, id_wb_en, mem_wb_en} = 5'($urandom);
         id_cmd = CW'($urandom);
         {sel_a, sel_b, sel_st} = 6'($urandom);
         id_val1 = $urandom; id_val2 = $urandom; id_st_val = $urandom;
         mem_alu_res = $urandom; wb_value = $urandom;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
